// File: rtl/sqrt_seq_hs_pkg.sv
// Shared types and helpers for the sequential handshaked square-root unit.
package sqrt_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } sqrt_state_e;

    localparam int TC_UNS     = 0;
    localparam int TC_SIGNED  = 1;
    localparam int TC_RUNTIME = 2;

    function automatic int sqrt_root_w(input int width);
        return (width + 1) / 2;
    endfunction

endpackage

// File: rtl/sqrt_seq_hs_if.sv
// Radicand/result stream bundle; out_rem exists only when SQRT_REMAINDER_EN is defined.
interface sqrt_seq_hs_if
    import sqrt_seq_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int RW = sqrt_root_w(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_radicand;
    logic             in_tc;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    out_root;
    logic             out_neg;
`ifdef SQRT_REMAINDER_EN
    logic [RW:0]      out_rem;

    modport master (output in_valid, in_radicand, in_tc, out_ready,
                    input  in_ready, out_valid, out_root, out_neg, out_rem);
    modport slave  (input  in_valid, in_radicand, in_tc, out_ready,
                    output in_ready, out_valid, out_root, out_neg, out_rem);
`else
    modport master (output in_valid, in_radicand, in_tc, out_ready,
                    input  in_ready, out_valid, out_root, out_neg);
    modport slave  (input  in_valid, in_radicand, in_tc, out_ready,
                    output in_ready, out_valid, out_root, out_neg);
`endif

endinterface

// File: rtl/sqrt_seq_hs_step.sv
// One restoring square-root iteration: brings in two radicand bits, decides one root bit.
module sqrt_seq_step #(
    parameter int RW = 4
) (
    input  logic [RW+1:0] part_rem,
    input  logic [RW-1:0] part_root,
    input  logic [1:0]    rad_bits,
    output logic [RW+1:0] next_rem,
    output logic          root_bit
);
    logic [RW+1:0] shifted_s;
    logic [RW+1:0] trial_s;

    // The partial remainder never exceeds twice the partial root, so the shift stays in range.
    always_comb begin
        shifted_s = (part_rem << 2) | {{RW{1'b0}}, rad_bits};
        trial_s   = {part_root, 2'b01};
        if (shifted_s >= trial_s) begin
            next_rem = shifted_s - trial_s;
            root_bit = 1'b1;
        end else begin
            next_rem = shifted_s;
            root_bit = 1'b0;
        end
    end

endmodule

// File: rtl/sqrt_seq_hs.sv
// Multi-cycle floor(sqrt(|x|)) behind valid/ready; SQRT_REMAINDER_EN adds out_rem.
module sqrt_seq_hs
    import sqrt_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TC_MODE = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    sqrt_seq_hs_if.slave  bus
);
    localparam int RW = sqrt_root_w(WIDTH);
    localparam int CW = $clog2(RW + 1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CALC = ST_CALC;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]      state_r, next_s;
    logic [CW-1:0]   cnt_r;
    logic [2*RW-1:0] rad_r;
    logic [RW+1:0]   rem_r;
    logic [RW-1:0]   root_r;
    logic            neg_r;
    logic            in_ready_r, out_valid_r, out_neg_r;
    logic [RW-1:0]   out_root_r;
    logic            tc_s, neg_s, accept_s, step_bit_s;
    logic [WIDTH-1:0] mag_s;
    logic [2*RW-1:0] pad_s;
    logic [RW+1:0]   step_rem_s;

    // Operand decode: sign handling and zero-padding to an even bit count.
    always_comb begin
        tc_s     = (TC_MODE == TC_SIGNED) || ((TC_MODE == TC_RUNTIME) && bus.in_tc);
        neg_s    = tc_s && bus.in_radicand[WIDTH-1];
        accept_s = bus.in_valid && in_ready_r;
        // The negated most-negative value reads back correctly as an unsigned magnitude.
        if (neg_s) begin
            mag_s = ~bus.in_radicand + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_s = bus.in_radicand;
        end
        pad_s = '0;
        pad_s[WIDTH-1:0] = mag_s;
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) next_s = S_CALC;
                else          next_s = S_IDLE;
            end
            S_CALC: begin
                if (cnt_r == '0) next_s = S_DONE;
                else             next_s = S_CALC;
            end
            S_DONE: begin
                if (out_valid_r && bus.out_ready) next_s = S_IDLE;
                else                              next_s = S_DONE;
            end
            default: next_s = S_IDLE;
        endcase
    end

    sqrt_seq_step #(.RW(RW)) u_step (
        .part_rem  (rem_r),
        .part_root (root_r),
        .rad_bits  (rad_r[2*RW-1 -: 2]),
        .next_rem  (step_rem_s),
        .root_bit  (step_bit_s)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            rad_r       <= '0;
            rem_r       <= '0;
            root_r      <= '0;
            neg_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_root_r  <= '0;
            out_neg_r   <= 1'b0;
        end else begin
            state_r    <= next_s;
            in_ready_r <= (next_s == S_IDLE);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        rad_r  <= pad_s;
                        rem_r  <= '0;
                        root_r <= '0;
                        neg_r  <= neg_s;
                        cnt_r  <= CW'(RW - 1);
                    end
                end
                S_CALC: begin
                    rad_r  <= rad_r << 2;
                    rem_r  <= step_rem_s;
                    root_r <= (root_r << 1) | RW'(step_bit_s);
                    cnt_r  <= cnt_r - CW'(1);
                end
                S_DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_root_r  <= root_r;
                        out_neg_r   <= neg_r;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SQRT_REMAINDER_EN
    logic [RW:0] out_rem_r;

    // Final remainder, loaded alongside the root.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rem_r <= '0;
        end else if ((state_r == S_DONE) && !out_valid_r) begin
            out_rem_r <= rem_r[RW:0];
        end
    end

    assign bus.out_rem = out_rem_r;
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_root  = out_root_r;
    assign bus.out_neg   = out_neg_r;

endmodule

// File: tb/tb_sqrt_seq_hs.sv
// Directed bench: 8-bit runtime-signed unit and 7-bit unsigned unit, hand-computed roots.
module tb_sqrt_seq_hs;
    import sqrt_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sqrt_seq_hs_if #(.WIDTH(8)) bus_a ();
    sqrt_seq_hs_if #(.WIDTH(7)) bus_b ();

    sqrt_seq_hs #(.WIDTH(8), .TC_MODE(TC_RUNTIME)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    sqrt_seq_hs #(.WIDTH(7), .TC_MODE(TC_UNS))     dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready_a();
        for (int i = 0; i < 20; i++) begin
            if (bus_a.in_ready === 1'b1) break;
            @(posedge clk); #1;
        end
        check("a_in_ready", bus_a.in_ready, 1);
    endtask

    task automatic send_a(input logic [7:0] rad, input logic tc);
        wait_ready_a();
        bus_a.in_radicand = rad;
        bus_a.in_tc       = tc;
        bus_a.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid    = 1'b0;
        bus_a.in_radicand = ~rad;
        bus_a.in_tc       = ~tc;
    endtask

    task automatic run_a(input logic [7:0] rad, input logic tc, input int exp_root,
                         input int exp_neg, input int exp_rem, input int hold);
        int lat;
        send_a(rad, tc);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (bus_a.out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("a_latency", lat, 5);
        check("a_root", bus_a.out_root, exp_root);
        check("a_neg", bus_a.out_neg, exp_neg);
`ifdef SQRT_REMAINDER_EN
        check("a_rem", bus_a.out_rem, exp_rem);
`else
        if (exp_rem < 0) $display("unexpected negative remainder request");
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_valid", bus_a.out_valid, 1);
            check("bp_root", bus_a.out_root, exp_root);
            check("bp_neg", bus_a.out_neg, exp_neg);
            check("bp_in_ready", bus_a.in_ready, 0);
        end
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
        check("a_valid_drop", bus_a.out_valid, 0);
        check("a_ready_back", bus_a.in_ready, 1);
    endtask

    initial begin
        int lat;
        bus_a.in_valid = 1'b0; bus_a.in_radicand = '0; bus_a.in_tc = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_radicand = '0; bus_b.in_tc = 1'b0; bus_b.out_ready = 1'b0;

        #1;
        check("rst_in_ready", bus_a.in_ready, 0);
        check("rst_valid", bus_a.out_valid, 0);
        check("rst_root", bus_a.out_root, 0);
        check("rst_neg", bus_a.out_neg, 0);
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", bus_a.in_ready, 1);

        run_a(8'd255, 1'b0, 15, 0, 30, 0);
        run_a(8'd0,   1'b0, 0,  0, 0,  0);
        run_a(8'h80,  1'b0, 11, 0, 7,  10);
        run_a(8'h80,  1'b1, 11, 1, 7,  0);
        run_a(8'hF7,  1'b1, 3,  1, 0,  0);
        run_a(8'h7F,  1'b1, 11, 0, 6,  0);
        run_a(8'h40,  1'b0, 8,  0, 0,  0);

        // Abort in the second CALC cycle.
        send_a(8'd200, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", bus_a.in_ready, 0);
        check("abort_valid", bus_a.out_valid, 0);
        check("abort_root", bus_a.out_root, 0);
        check("abort_neg", bus_a.out_neg, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus_a.out_valid !== 1'b0) lat++;
        end
        check("abort_no_valid", lat, 0);
        run_a(8'd144, 1'b0, 12, 0, 0, 0);

        // Odd width: 7-bit unsigned 127.
        for (int i = 0; i < 20; i++) begin
            if (bus_b.in_ready === 1'b1) break;
            @(posedge clk); #1;
        end
        check("b_in_ready", bus_b.in_ready, 1);
        bus_b.in_radicand = 7'd127;
        bus_b.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus_b.in_valid    = 1'b0;
        bus_b.in_radicand = 7'd0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (bus_b.out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("b_latency", lat, 5);
        check("b_root", bus_b.out_root, 11);
        check("b_neg", bus_b.out_neg, 0);
`ifdef SQRT_REMAINDER_EN
        check("b_rem", bus_b.out_rem, 6);
`endif
        bus_b.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_b.out_ready = 1'b0;
        check("b_valid_drop", bus_b.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
